// File: rtl/demux1x16_tdm_pkg.sv
// Shared types and constants for the 16-slot TDM receive demultiplexer.
// Build option DEMUX_STRICT_SYNC_EN is consumed by demux1x16_tdm, not here.
package tdm_pkg;

    localparam int NCH   = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    typedef logic [SEL_W-1:0] slot_t;

    localparam slot_t FIRST_SLOT = slot_t'(0);
    localparam slot_t LAST_SLOT  = slot_t'(NCH - 1);

endpackage

// File: rtl/demux1x16_tdm_slot_ctr4.sv
// Mod-16 slot counter for the TDM demux.
// Clear wins over load-to-1 on a resync, and both win over increment.
module slot_ctr4
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  load1,
    input  logic  clr,
    output slot_t count,
    output logic  is_last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= FIRST_SLOT;
        end else if (load1) begin
            count <= slot_t'(1);
        end else if (inc) begin
            count <= count + slot_t'(1);
        end
    end

    assign is_last = (count == LAST_SLOT);

endmodule

// File: rtl/demux1x16_tdm.sv
// 1-to-16 TDM demultiplexer: collects one DW-bit beat per slot into a frame.
// Define DEMUX_STRICT_SYNC_EN to require SYNC on every slot-0 beat.
//
// Handshake: a beat is any cycle with in_valid=1 (no backpressure); sync is
// only meaningful when in_valid=1. out_valid is a one-cycle pulse with out
// already holding the new frame; sync_err is a one-cycle pulse that never
// coincides with out_valid.
module demux1x16_tdm
    import tdm_pkg::tdm_state_t;
    import tdm_pkg::slot_t;
    import tdm_pkg::SEL_W;
    import tdm_pkg::HUNT;
    import tdm_pkg::LOCKED;
    import tdm_pkg::FIRST_SLOT;
#(
    parameter int DW  = 1,
    parameter int NCH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     in,
    input  logic              in_valid,
    input  logic              sync,
    output logic [NCH*DW-1:0] out,
    output logic              out_valid,
    output logic [SEL_W-1:0]  sel,
    output logic              sync_err,
    output tdm_state_t        dbg_state
);

    generate
        if (NCH != tdm_pkg::NCH) begin : g_bad_nch
            $error("demux1x16_tdm supports NCH == 16 only");
        end
    endgenerate

`ifdef DEMUX_STRICT_SYNC_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    tdm_state_t              state;
    tdm_state_t              state_nxt;
    logic [NCH-2:0][DW-1:0]  shadow;
    slot_t                   slot;
    logic                    is_last;

    logic  ctr_inc;
    logic  ctr_load1;
    logic  ctr_clr;
    logic  wr_en;
    slot_t wr_idx;
    logic  emit;
    logic  err;

    slot_ctr4 u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .inc     (ctr_inc),
        .load1   (ctr_load1),
        .clr     (ctr_clr),
        .count   (slot),
        .is_last (is_last)
    );

    always_comb begin
        ctr_inc   = 1'b0;
        ctr_load1 = 1'b0;
        ctr_clr   = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = slot;
        emit      = 1'b0;
        err       = 1'b0;
        state_nxt = state;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        wr_en     = 1'b1;
                        wr_idx    = FIRST_SLOT;
                        ctr_load1 = 1'b1;
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync && slot != FIRST_SLOT) begin
                        // Early sync: abandon the partial frame, restart at slot 0.
                        err       = 1'b1;
                        wr_en     = 1'b1;
                        wr_idx    = FIRST_SLOT;
                        ctr_load1 = 1'b1;
                    end else if (STRICT && !sync && slot == FIRST_SLOT) begin
                        err       = 1'b1;
                        ctr_clr   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        wr_en   = ~is_last;
                        ctr_inc = 1'b1;
                        emit    = is_last;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            out       <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            shadow    <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= emit;
            sync_err  <= err;
            // Slot 15 bypasses the shadow so the frame lands on the same edge.
            if (emit) begin
                out <= {in, shadow};
            end
            for (int k = 0; k < NCH - 1; k++) begin
                if (wr_en && wr_idx == slot_t'(k)) begin
                    shadow[k] <= in;
                end
            end
        end
    end

    assign sel       = slot;
    assign dbg_state = state;

endmodule

// File: tb/tb_demux1x16_tdm.sv
// Scoreboard bench for demux1x16_tdm: directed frames, gaps, early/missing sync, reset.
module tb_demux1x16_tdm;

    localparam int DW  = 1;
    localparam int NCH = 16;

    logic              clk;
    logic              rst;
    logic [DW-1:0]     in;
    logic              in_valid;
    logic              sync;
    logic [NCH*DW-1:0] out;
    logic              out_valid;
    logic [3:0]        sel;
    logic              sync_err;
    tdm_pkg::tdm_state_t dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [NCH*DW-1:0] exp_q[$];
    logic              err_q[$];

    demux1x16_tdm #(.DW(DW), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .sync      (sync),
        .out       (out),
        .out_valid (out_valid),
        .sel       (sel),
        .sync_err  (sync_err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        in_valid = 1'b0;
        sync     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic d, input logic s);
        in       = d;
        sync     = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sync     = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] v, input bit gaps, input bit with_sync);
        for (int k = 0; k < 16; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 3));
                check("sel_holds_in_gap", 32'(sel), 32'(k));
            end
            check("sel_before_beat", 32'(sel), 32'(k));
            beat(v[k], with_sync && k == 0);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid || sync_err)
                check("valid_err_exclusive", 32'(out_valid && sync_err), 32'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame: got=%0h want=none", out);
                end else begin
                    check("frame_out", 32'(out), 32'(exp_q.pop_front()));
                end
            end
            if (sync_err) begin
                if (err_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_sync_err: got=1 want=0");
                end else begin
                    check("sync_err_pulse", 32'(sync_err), 32'(err_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in       = '0;
        in_valid = 1'b0;
        sync     = 1'b0;

        // Reset and idle
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_out", 32'(out), 32'd0);
            check("rst_sel", 32'(sel), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("idle_out", 32'(out), 32'd0);
            check("idle_flags", {30'd0, out_valid, sync_err}, 32'd0);
            check("idle_sel", 32'(sel), 32'd0);
        end
        check("idle_state", 32'(dbg_state), 32'(tdm_pkg::HUNT));

        // Junk beats in HUNT are dropped, then one frame
        repeat (3) beat(1'b1, 1'b0);
        check("hunt_drop_sel", 32'(sel), 32'd0);
        check("hunt_drop_state", 32'(dbg_state), 32'(tdm_pkg::HUNT));
        exp_q.push_back(16'hA5C3);
        send_frame(16'hA5C3, 1'b0, 1'b1);
        check("frame_latency_valid", 32'(out_valid), 32'd1);
        check("frame_latency_out", 32'(out), 32'hA5C3);
        check("sel_wrap", 32'(sel), 32'd0);
        idle(1);
        check("valid_one_cycle", 32'(out_valid), 32'd0);
        check("out_stable", 32'(out), 32'hA5C3);

        // Gapped frame then back-to-back frame
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'hFFFF);
        send_frame(16'h1234, 1'b1, 1'b1);
        send_frame(16'hFFFF, 1'b0, 1'b1);
        check("b2b_out", 32'(out), 32'hFFFF);
        idle(2);

        // Early sync: 8 beats of a frame, then a fresh frame of 16'h0F0F
        beat(1'b1, 1'b1);
        repeat (7) beat(1'b0, 1'b0);
        check("early_sel", 32'(sel), 32'd8);
        err_q.push_back(1'b1);
        exp_q.push_back(16'h0F0F);
        beat(1'b1, 1'b1);
        check("early_err_now", 32'(sync_err), 32'd1);
        check("early_sel_resync", 32'(sel), 32'd1);
        for (int k = 1; k < 16; k++) begin
            logic [15:0] v;
            v = 16'h0F0F;
            beat(v[k], 1'b0);
        end
        check("early_out", 32'(out), 32'h0F0F);
        idle(2);

        // Missing sync on the second of two frames
        exp_q.push_back(16'h00FF);
        send_frame(16'h00FF, 1'b0, 1'b1);
`ifdef DEMUX_STRICT_SYNC_EN
        err_q.push_back(1'b1);
        beat(1'b1, 1'b0);
        check("missing_err_now", 32'(sync_err), 32'd1);
        check("missing_state", 32'(dbg_state), 32'(tdm_pkg::HUNT));
        for (int k = 1; k < 16; k++) begin
            logic [15:0] v;
            v = 16'h3C3C;
            beat(v[k], 1'b0);
        end
        check("missing_sel", 32'(sel), 32'd0);
        check("missing_out_kept", 32'(out), 32'h00FF);
`else
        exp_q.push_back(16'h3C3C);
        send_frame(16'h3C3C, 1'b0, 1'b0);
        check("freerun_state", 32'(dbg_state), 32'(tdm_pkg::LOCKED));
        check("freerun_out", 32'(out), 32'h3C3C);
`endif
        idle(2);

        // Reset in the middle of a frame at slot 9
        beat(1'b1, 1'b1);
        repeat (8) beat(1'b1, 1'b0);
        check("mid_sel", 32'(sel), 32'd9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_sel", 32'(sel), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(tdm_pkg::HUNT));
        idle(2);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        exp_q.push_back(16'h8001);
        send_frame(16'h8001, 1'b0, 1'b1);
        check("post_rst_out", 32'(out), 32'h8001);
        idle(4);

        check("frames_drained", 32'(exp_q.size()), 32'd0);
        check("errs_drained", 32'(err_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
